// File: rtl/sa_autosa_sync_pkg.sv
// Shared constants and elaboration helpers for the SA boundary input synchroniser.
// Capture-mode encodings, clog2 and parameter range checks.
package sa_autosa_sync_pkg;

    localparam logic [1:0] EVT_NONE = 2'b00;
    localparam logic [1:0] EVT_RISE = 2'b01;
    localparam logic [1:0] EVT_FALL = 2'b10;
    localparam logic [1:0] EVT_BOTH = 2'b11;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic bit n_ch_ok(input int unsigned n_ch);
        return (n_ch >= 1) && (n_ch <= 32);
    endfunction

    function automatic bit stages_ok(input int unsigned stages);
        return (stages >= 2) && (stages <= 4);
    endfunction

    function automatic bit filt_cyc_ok(input int unsigned filt_cyc);
        return (filt_cyc >= 1) && (filt_cyc <= 255);
    endfunction

endpackage

// File: rtl/sa_autosa_sync_filt_ch.sv
// One synchroniser channel: flop chain, stability filter and registered edge pulses.
// level_o only follows the synchronised input after FILT_CYC consecutive mismatching cycles.
module sa_autosa_sync_filt_ch
    import sa_autosa_sync_pkg::*;
#(
    parameter int unsigned STAGES   = 3,
    parameter int unsigned FILT_CYC = 4,
    parameter logic        RST_VAL  = 1'b0
) (
    input  logic o_clk,
    input  logic o_rst,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = clog2(FILT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

    logic [STAGES-1:0] chain_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              sync_s;
    logic              commit;

    assign sync_s = chain_q[STAGES-1];

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        commit  = 1'b0;
        // Any cycle where the input agrees with level_q rejects the pending change.
        if (sync_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                commit = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (commit) begin
            level_d = sync_s;
        end
        rise_d = commit & sync_s;
        fall_d = commit & ~sync_s;
    end

    always_ff @(posedge o_clk) begin
        if (o_rst) begin
            chain_q <= {STAGES{RST_VAL}};
            cnt_q   <= '0;
            level_q <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/sa_autosa_ssa_sync3d_multi.sv
// Multi-channel input synchroniser with sticky edge capture, write-1-clear and interrupt OR.
// Each channel is fully independent; only irq_o combines them.
module sa_autosa_ssa_sync3d_multi
    import sa_autosa_sync_pkg::*;
#(
    parameter int unsigned    N_CH     = 8,
    parameter int unsigned    STAGES   = 3,
    parameter int unsigned    FILT_CYC = 4,
    parameter logic [N_CH-1:0] RST_VAL = '0
) (
    input  logic              o_clk,
    input  logic              o_rst,
    input  logic [N_CH-1:0]   async_i,
    input  logic [2*N_CH-1:0] evt_mode_i,
    input  logic [N_CH-1:0]   evt_en_i,
    input  logic [N_CH-1:0]   evt_clr_i,
    output logic [N_CH-1:0]   level_o,
    output logic [N_CH-1:0]   rise_o,
    output logic [N_CH-1:0]   fall_o,
    output logic [N_CH-1:0]   event_o,
    output logic              irq_o
);

    if (!n_ch_ok(N_CH)) begin : g_bad_n_ch
        $error("N_CH out of range 1..32");
    end
    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("STAGES out of range 2..4");
    end
    if (!filt_cyc_ok(FILT_CYC)) begin : g_bad_filt_cyc
        $error("FILT_CYC out of range 1..255");
    end

    logic [N_CH-1:0] event_q, event_d;
    logic [N_CH-1:0] evt_set;

    for (genvar n = 0; n < N_CH; n++) begin : g_ch
        sa_autosa_sync_filt_ch #(
            .STAGES   (STAGES),
            .FILT_CYC (FILT_CYC),
            .RST_VAL  (RST_VAL[n])
        ) u_ch (
            .o_clk   (o_clk),
            .o_rst   (o_rst),
            .async_i (async_i[n]),
            .level_o (level_o[n]),
            .rise_o  (rise_o[n]),
            .fall_o  (fall_o[n])
        );
    end

    always_comb begin
        evt_set = '0;
        for (int n = 0; n < N_CH; n++) begin
            evt_set[n] = (rise_o[n] & evt_mode_i[2*n]) | (fall_o[n] & evt_mode_i[2*n+1]);
        end
        // A new event wins over a clear in the same cycle.
        event_d = evt_set | (event_q & ~evt_clr_i);
    end

    always_ff @(posedge o_clk) begin
        if (o_rst) begin
            event_q <= '0;
        end else begin
            event_q <= event_d;
        end
    end

    assign event_o = event_q;
    assign irq_o   = |(event_q & evt_en_i);

endmodule

// File: tb/tb_sa_autosa_ssa_sync3d_multi.sv
// Directed bench for sa_autosa_ssa_sync3d_multi: default 8-channel build plus a
// minimal N_CH=1, STAGES=2, FILT_CYC=1 build sharing clock and reset.
module tb_sa_autosa_ssa_sync3d_multi;
    import sa_autosa_sync_pkg::*;

    logic        clk;
    logic        rst;
    logic [7:0]  async_v;
    logic [15:0] mode_v;
    logic [7:0]  en_v;
    logic [7:0]  clr_v;
    logic [7:0]  level_v, rise_v, fall_v, event_v;
    logic        irq_v;

    logic        async_s;
    logic [1:0]  mode_s;
    logic        en_s, clr_s;
    logic        level_s, rise_s, fall_s, event_s, irq_s;

    int checks   = 0;
    int failures = 0;
    int bad;

    sa_autosa_ssa_sync3d_multi u_dut (
        .o_clk      (clk),
        .o_rst      (rst),
        .async_i    (async_v),
        .evt_mode_i (mode_v),
        .evt_en_i   (en_v),
        .evt_clr_i  (clr_v),
        .level_o    (level_v),
        .rise_o     (rise_v),
        .fall_o     (fall_v),
        .event_o    (event_v),
        .irq_o      (irq_v)
    );

    sa_autosa_ssa_sync3d_multi #(
        .N_CH     (1),
        .STAGES   (2),
        .FILT_CYC (1),
        .RST_VAL  (1'b0)
    ) u_dut_small (
        .o_clk      (clk),
        .o_rst      (rst),
        .async_i    (async_s),
        .evt_mode_i (mode_s),
        .evt_en_i   (en_s),
        .evt_clr_i  (clr_s),
        .level_o    (level_s),
        .rise_o     (rise_s),
        .fall_o     (fall_s),
        .event_o    (event_s),
        .irq_o      (irq_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; async_v = 8'hFF; mode_v = '0; en_v = '0; clr_v = '0;
        async_s = 1'b0; mode_s = EVT_BOTH; en_s = 1'b1; clr_s = 1'b0;

        // Reset with all inputs high
        tick(); tick();
        chk("rst_level", 32'(level_v), 32'h00);
        chk("rst_rise", 32'(rise_v), 32'h00);
        chk("rst_fall", 32'(fall_v), 32'h00);
        chk("rst_event", 32'(event_v), 32'h00);
        chk("rst_irq", 32'(irq_v), 32'h0);
        chk("rst_small_level", 32'(level_s), 32'h0);

        rst = 1'b0;
        repeat (6) tick();
        chk("post_rst_edge6_level", 32'(level_v), 32'h00);
        tick();
        chk("post_rst_edge7_level", 32'(level_v), 32'hFF);
        chk("post_rst_edge7_rise", 32'(rise_v), 32'hFF);
        chk("post_rst_edge7_fall", 32'(fall_v), 32'h00);
        tick();
        chk("post_rst_edge8_rise", 32'(rise_v), 32'h00);

        // All channels fall
        async_v = 8'h00;
        repeat (6) tick();
        chk("fall_edge6_level", 32'(level_v), 32'hFF);
        tick();
        chk("fall_edge7_level", 32'(level_v), 32'h00);
        chk("fall_edge7_fall", 32'(fall_v), 32'hFF);
        chk("fall_edge7_rise", 32'(rise_v), 32'h00);
        tick();
        chk("fall_edge8_fall", 32'(fall_v), 32'h00);

        // Three-cycle glitch on ch0 must be rejected
        async_v = 8'h01;
        repeat (3) tick();
        async_v = 8'h00;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (level_v[0] !== 1'b0 || rise_v[0] !== 1'b0) bad = 1;
        end
        chk("glitch3_rejected", 32'(bad), 32'h0);

        // Sustained high on ch0 commits at edge 7
        async_v = 8'h01;
        repeat (6) tick();
        chk("ch0_edge6_level", 32'(level_v), 32'h00);
        tick();
        chk("ch0_edge7_level", 32'(level_v), 32'h01);
        chk("ch0_edge7_rise", 32'(rise_v), 32'h01);
        tick();
        chk("ch0_edge8_rise", 32'(rise_v), 32'h00);

        // ch1 in rise mode, interrupt enabled
        mode_v = 16'(EVT_RISE) << 2;
        en_v = 8'h02;
        async_v = 8'h03;
        repeat (7) tick();
        chk("ch1_rise_pulse", 32'(rise_v), 32'h02);
        chk("ch1_event_not_yet", 32'(event_v), 32'h00);
        tick();
        chk("ch1_event_set", 32'(event_v), 32'h02);
        chk("ch1_irq_set", 32'(irq_v), 32'h1);
        en_v = 8'h00;
        #1;
        chk("irq_masked", 32'(irq_v), 32'h0);
        en_v = 8'h02;
        #1;

        // Lone clear
        clr_v = 8'h02;
        tick();
        clr_v = 8'h00;
        chk("clr_event", 32'(event_v), 32'h00);
        chk("clr_irq", 32'(irq_v), 32'h0);

        // Fall on ch1 is not captured in rise mode
        async_v = 8'h01;
        repeat (7) tick();
        chk("ch1_fall_pulse", 32'(fall_v), 32'h02);
        tick();
        chk("ch1_fall_not_captured", 32'(event_v), 32'h00);

        // Clear coincident with rise pulse: set wins
        async_v = 8'h03;
        repeat (7) tick();
        chk("ch1_rise_again", 32'(rise_v), 32'h02);
        clr_v = 8'h02;
        tick();
        clr_v = 8'h00;
        chk("set_beats_clear", 32'(event_v), 32'h02);
        chk("set_beats_clear_irq", 32'(irq_v), 32'h1);

        // ch3 in fall mode: rise ignored, fall captured
        mode_v = (16'(EVT_RISE) << 2) | (16'(EVT_FALL) << 6);
        async_v = 8'h0B;
        repeat (7) tick();
        chk("ch3_rise_pulse", 32'(rise_v), 32'h08);
        tick();
        chk("ch3_rise_ignored", 32'(event_v), 32'h02);
        async_v = 8'h03;
        repeat (7) tick();
        chk("ch3_fall_pulse", 32'(fall_v), 32'h08);
        tick();
        chk("ch3_fall_captured", 32'(event_v), 32'h0A);

        // Alternating ch3 every cycle never commits
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            async_v[3] = ~async_v[3];
            tick();
            if (level_v[3] !== 1'b0 || rise_v[3] !== 1'b0 || fall_v[3] !== 1'b0) bad = 1;
        end
        async_v[3] = 1'b0;
        repeat (8) begin
            tick();
            if (level_v[3] !== 1'b0 || rise_v[3] !== 1'b0) bad = 1;
        end
        chk("ch3_alternate_rejected", 32'(bad), 32'h0);

        // Reset while ch2 filter count is 2
        async_v = 8'h07;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_level", 32'(level_v), 32'h00);
        chk("midrst_rise", 32'(rise_v), 32'h00);
        chk("midrst_fall", 32'(fall_v), 32'h00);
        chk("midrst_event", 32'(event_v), 32'h00);
        chk("midrst_irq", 32'(irq_v), 32'h0);
        repeat (6) tick();
        chk("midrst_edge6_level", 32'(level_v), 32'h00);
        tick();
        chk("midrst_edge7_level", 32'(level_v), 32'h07);
        chk("midrst_edge7_rise", 32'(rise_v), 32'h07);

        // Minimal build: step commits at edge 3
        async_s = 1'b1;
        tick(); tick();
        chk("small_edge2_level", 32'(level_s), 32'h0);
        tick();
        chk("small_edge3_level", 32'(level_s), 32'h1);
        chk("small_edge3_rise", 32'(rise_s), 32'h1);
        tick();
        chk("small_edge4_rise", 32'(rise_s), 32'h0);
        chk("small_event", 32'(event_s), 32'h1);
        chk("small_irq", 32'(irq_s), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
